axi_lite_master_ctrl: RTL and testbench

//  AXI4-Lite initiator: turns a single-beat command/response handshake from local logic into AXI-Lite read/write transactions.

---
 rtl/axi_lite_master_ctrl.sv | 147 ++++++++++++++
 tb/tb_axi_lite_master_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite initiator: one command in flight, converted to an AXI-Lite read or write.
// A sticky watchdog flags a stalled slave without aborting the transaction.
module axi_lite_master_ctrl #(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 32,
    parameter int DATA_BYTES = DATA_BITS / 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [DATA_BITS-1:0]  cmd_wdata,
    input  logic [DATA_BYTES-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_BITS-1:0]  rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  stall_flag,
    output logic [ADDR_BITS-1:0]  m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_BITS-1:0]  m_axi_wdata,
    output logic [DATA_BYTES-1:0] m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_BITS-1:0]  m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_BITS-1:0]  m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RESP} state_t;

    localparam int CNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0] WD_MAX  = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] WD_LAST = CNT_BITS'(TIMEOUT - 1);

    state_t              state;
    logic [CNT_BITS-1:0] wd_cnt;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state         <= IDLE;
            wd_cnt        <= '0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            stall_flag    <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            // Watchdog only ages while waiting on the slave; saturates so the flag stays set.
            if (state inside {WR, WR_B, RD_AR, RD_R}) begin
                if (wd_cnt != WD_MAX) begin
                    wd_cnt <= wd_cnt + CNT_BITS'(1);
                    if (wd_cnt == WD_LAST) stall_flag <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        wd_cnt     <= '0;
                        stall_flag <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_AR;
                        end
                    end
                end
                WR: begin
                    // AW and W retire independently; move on once neither is still pending.
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_write    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RD_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_write    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Directed + randomized bench for axi_lite_master_ctrl with a delay-programmable AXI-Lite slave.
module tb_axi_lite_master_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        stall_flag;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    axi_lite_master_ctrl #(.ADDR_BITS(32), .DATA_BITS(32), .DATA_BYTES(4), .TIMEOUT(TO)) dut (
        .m_axi_aclk(clk), .m_axi_areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .stall_flag(stall_flag),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int total = 0, bad = 0;

    // Slave configuration, changed by the main sequence only while the DUT is idle.
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [31:0] rd_value = '0;
    logic [1:0]  resp_value = '0;

    // Handshake bookkeeping, written only by the monitor.
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_hs = 0;
    int          b_skip = 0, r_skip = 0, rst_cnt = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (areset) begin
                rst_cnt++;
                b_skip = imin(aw_hs, w_hs) - b_hs;
                r_skip = ar_hs - r_hs;
            end else begin
                if (awvalid && awready) begin aw_hs++; cap_awaddr = awaddr; end
                if (wvalid && wready) begin w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; end
                if (bvalid && bready) b_hs++;
                if (arvalid && arready) begin ar_hs++; cap_araddr = araddr; end
                if (rvalid && rready) r_hs++;
                if (rsp_valid && rsp_ready) rsp_hs++;
            end
        end
    end

    // Slave: readies after programmed waits, one B per AW+W pair, one R per AR.
    initial begin
        int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
        int b_mark = 0, r_mark = 0, rst_seen = 0;
        forever begin
            @(negedge clk);
            if (rst_cnt != rst_seen) begin
                rst_seen = rst_cnt;
                bvalid = 1'b0; rvalid = 1'b0; b_wait = 0; r_wait = 0;
            end
            if (awvalid) begin awready = (aw_wait >= aw_delay); aw_wait++; end
            else begin awready = 1'b0; aw_wait = 0; end
            if (wvalid) begin wready = (w_wait >= w_delay); w_wait++; end
            else begin wready = 1'b0; w_wait = 0; end
            if (arvalid) begin arready = (ar_wait >= ar_delay); ar_wait++; end
            else begin arready = 1'b0; ar_wait = 0; end
            if (bvalid) begin
                if (b_hs != b_mark) bvalid = 1'b0;
            end else if (imin(aw_hs, w_hs) > b_hs + b_skip) begin
                if (b_wait >= b_delay) begin
                    bvalid = 1'b1; bresp = resp_value; b_mark = b_hs; b_wait = 0;
                end else b_wait++;
            end
            if (rvalid) begin
                if (r_hs != r_mark) rvalid = 1'b0;
            end else if (ar_hs > r_hs + r_skip) begin
                if (r_wait >= r_delay) begin
                    rvalid = 1'b1; rdata = rd_value; rresp = resp_value; r_mark = r_hs; r_wait = 0;
                end else r_wait++;
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one command from idle; returns at the first negedge after the accepting edge.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        chk1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_wdata = $urandom;
    endtask

    // k = number of clock edges after the accepting edge until rsp_valid is seen.
    task automatic wait_rsp(output int k);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk1("rsp_arrives", k < 100, 1'b1);
    endtask

    task automatic take_rsp(input logic ew, input logic [31:0] ed, input logic [1:0] er, input int hold);
        chk1("rsp_valid", rsp_valid, 1'b1);
        chk1("rsp_write", rsp_write, ew);
        chk32("rsp_rdata", rsp_rdata, ed);
        chk32("rsp_resp", 32'(rsp_resp), 32'(er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk1("rsp_valid_hold", rsp_valid, 1'b1);
            chk32("rsp_resp_hold", 32'(rsp_resp), 32'(er));
            chk32("rsp_rdata_hold", rsp_rdata, ed);
            chk1("cmd_ready_busy", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("rsp_valid_drop", rsp_valid, 1'b0);
        chk1("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k, a0, w0, b0, r0;
        logic w;
        logic [31:0] a, d;
        logic [3:0] s;

        repeat (3) @(negedge clk);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_stall", stall_flag, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk32("rst_awaddr", awaddr, 32'h0);
        areset = 1'b0;
        @(negedge clk);

        // Basic write with exact cycle timing.
        b_delay = 1; resp_value = 2'b00;
        send_cmd(1'b1, 32'h4C, 32'h12345678, 4'hF);
        chk1("t1_awvalid", awvalid, 1'b1);
        chk1("t1_wvalid", wvalid, 1'b1);
        chk1("t1_cmd_ready", cmd_ready, 1'b0);
        chk32("t1_awaddr", awaddr, 32'h4C);
        chk32("t1_wdata", wdata, 32'h12345678);
        chk32("t1_wstrb", 32'(wstrb), 32'hF);
        @(negedge clk);
        chk1("t1_awvalid_drop", awvalid, 1'b0);
        chk1("t1_wvalid_drop", wvalid, 1'b0);
        chk1("t1_bready", bready, 1'b1);
        @(negedge clk);
        chk1("t1_no_rsp_yet", rsp_valid, 1'b0);
        @(negedge clk);
        chk1("t1_rsp_at_t4", rsp_valid, 1'b1);
        chk1("t1_bready_drop", bready, 1'b0);
        chk1("t1_stall", stall_flag, 1'b0);
        take_rsp(1'b1, 32'h0, 2'b00, 0);
        chk32("t1_cap_awaddr", cap_awaddr, 32'h4C);
        chk32("t1_cap_wdata", cap_wdata, 32'h12345678);

        // Basic read.
        rd_value = 32'hCAFEF00D;
        send_cmd(1'b0, 32'h90, 32'h0, 4'h0);
        chk1("t2_arvalid", arvalid, 1'b1);
        chk32("t2_araddr", araddr, 32'h90);
        wait_rsp(k);
        take_rsp(1'b0, 32'hCAFEF00D, 2'b00, 0);

        // W accepted five cycles after AW.
        b_delay = 0; w_delay = 5;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = rsp_hs;
        send_cmd(1'b1, 32'h13, 32'hA5A5_0101, 4'h6);
        chk1("t3_both_valid", awvalid & wvalid, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk1("t3_awvalid_low", awvalid, 1'b0);
            chk1("t3_wvalid_held", wvalid, 1'b1);
            chk1("t3_no_bready", bready, 1'b0);
        end
        @(negedge clk);
        chk1("t3_wvalid_drop", wvalid, 1'b0);
        chk1("t3_bready", bready, 1'b1);
        wait_rsp(k);
        take_rsp(1'b1, 32'h0, 2'b00, 0);
        repeat (3) @(negedge clk);
        chk32("t3_one_aw", 32'(aw_hs - a0), 32'd1);
        chk32("t3_one_w", 32'(w_hs - w0), 32'd1);
        chk32("t3_one_b", 32'(b_hs - b0), 32'd1);
        chk32("t3_one_rsp", 32'(rsp_hs - r0), 32'd1);
        chk32("t3_cap_wstrb", 32'(cap_wstrb), 32'h6);
        w_delay = 0;

        // SLVERR held against back-pressure on the response port.
        resp_value = 2'b10;
        send_cmd(1'b1, 32'h200, 32'h0BAD_F00D, 4'h1);
        wait_rsp(k);
        take_rsp(1'b1, 32'h0, 2'b10, 3);
        resp_value = 2'b00;

        // Watchdog on a withheld AR.
        ar_delay = 20; rd_value = 32'h5EED_1234;
        send_cmd(1'b0, 32'h44, 32'h0, 4'h0);
        for (int j = 0; j <= 12; j++) begin
            chk1("t5_stall_vs_age", stall_flag, (j >= TO));
            @(negedge clk);
        end
        wait_rsp(k);
        take_rsp(1'b0, 32'h5EED_1234, 2'b00, 0);
        chk1("t5_stall_sticky", stall_flag, 1'b1);
        ar_delay = 0;
        send_cmd(1'b0, 32'h48, 32'h0, 4'h0);
        chk1("t5_stall_cleared", stall_flag, 1'b0);
        wait_rsp(k);
        take_rsp(1'b0, 32'h5EED_1234, 2'b00, 0);

        // Reset while waiting for B.
        b_delay = 10;
        send_cmd(1'b1, 32'h80, 32'h1111_2222, 4'hF);
        @(negedge clk);
        chk1("t6_in_wr_b", bready, 1'b1);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        chk1("t6_bready_cleared", bready, 1'b0);
        chk1("t6_cmd_ready", cmd_ready, 1'b1);
        chk1("t6_rsp_valid", rsp_valid, 1'b0);
        repeat (12) @(negedge clk);
        chk1("t6_no_stale_rsp", rsp_valid, 1'b0);
        b_delay = 0; rd_value = 32'h7777_0001;
        send_cmd(1'b0, 32'h84, 32'h0, 4'h0);
        wait_rsp(k);
        take_rsp(1'b0, 32'h7777_0001, 2'b00, 0);

        // Randomized transactions against the pass-through model.
        for (int n = 0; n < 24; n++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom; d = $urandom; s = 4'($urandom_range(0, 15));
            aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4);
            ar_delay = $urandom_range(0, 6); b_delay = $urandom_range(0, 3);
            r_delay = $urandom_range(0, 3);
            resp_value = 2'($urandom_range(0, 3)); rd_value = $urandom;
            send_cmd(w, a, d, s);
            wait_rsp(k);
            chk1("rnd_stall", stall_flag, (k >= TO));
            if (w) begin
                chk32("rnd_awaddr", cap_awaddr, a);
                chk32("rnd_wdata", cap_wdata, d);
                chk32("rnd_wstrb", 32'(cap_wstrb), 32'(s));
            end else begin
                chk32("rnd_araddr", cap_araddr, a);
            end
            take_rsp(w, w ? 32'h0 : rd_value, resp_value, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
